// File: rtl/register_file_32x32_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_32x32_if
// Purpose  : Read/write bus bundle between the register file and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_32x32_if;
    logic [4:0]  Adr1;
    logic [4:0]  Adr2;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn;
    logic [31:0] Dout1;
    logic [31:0] Dout2;

    modport master (
        output Adr1, Adr2, Awr, Din, WrEn,
        input  Dout1, Dout2
    );

    modport slave (
        input  Adr1, Adr2, Awr, Din, WrEn,
        output Dout1, Dout2
    );
endinterface
`default_nettype wire

// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : register_file_32x32
// Purpose  : 32 x 32-bit register file, two async read ports, one sync write
//            port, R0 hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_32x32 (
    input  wire logic              Clk,
    input  wire logic              Rst,
    register_file_32x32_if.slave   bus
);

    logic [31:0] w_rd_array [32];

    // R0 has no storage at all, so it reads zero even before the first reset.
    assign w_rd_array[0] = '0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
        logic [31:0] data_q;
        logic [31:0] data_d;
        logic        w_we;

        assign w_we   = bus.WrEn && (bus.Awr == 5'(gi));
        assign data_d = w_we ? bus.Din : data_q;

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign w_rd_array[gi] = data_q;
    end

    assign bus.Dout1 = w_rd_array[bus.Adr1];
    assign bus.Dout2 = w_rd_array[bus.Adr2];

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_32x32
// Purpose  : Scoreboarded random and directed test of register_file_32x32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;

    typedef struct {
        int          id;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        strobe;
    int          checks;
    int          errors;
    int          next_id;
    exp_t        sb_q[$];
    logic [31:0] model [32];

    register_file_32x32_if bus ();

    register_file_32x32 dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: a plain array; R0 is never written so it stays zero.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic push_check();
        exp_t e;
        e.id = next_id;
        e.a1 = bus.Adr1;
        e.a2 = bus.Adr2;
        e.e1 = ref_read(bus.Adr1);
        e.e2 = ref_read(bus.Adr2);
        next_id++;
        sb_q.push_back(e);
        strobe = 1'b1;
        #1;
        strobe = 1'b0;
    endtask

    task automatic check(input logic [4:0] a1, input logic [4:0] a2);
        @(negedge Clk);
        bus.Adr1 = a1;
        bus.Adr2 = a2;
        #1;
        push_check();
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
        @(negedge Clk);
        bus.Awr  = a;
        bus.Din  = d;
        bus.WrEn = en;
        @(posedge Clk);
        if (en && Rst && a != 5'd0) model[a] = d;
        #1;
        bus.WrEn = 1'b0;
    endtask

    // Monitor: compares the read ports whenever a stimulus point is announced.
    initial begin
        forever begin
            @(posedge strobe);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got empty queue required entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (bus.Dout1 !== e.e1) begin
                    errors++;
                    $display("FAIL chk%0d Dout1 adr=%0d got %h required %h", e.id, e.a1, bus.Dout1, e.e1);
                end
                checks++;
                if (bus.Dout2 !== e.e2) begin
                    errors++;
                    $display("FAIL chk%0d Dout2 adr=%0d got %h required %h", e.id, e.a2, bus.Dout2, e.e2);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        next_id  = 0;
        strobe   = 1'b0;
        Rst      = 1'b0;
        bus.Adr1 = '0;
        bus.Adr2 = '0;
        bus.Awr  = '0;
        bus.Din  = '0;
        bus.WrEn = 1'b0;
        clear_model();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        // Reset state
        check(5'd0, 5'd0);
        check(5'd1, 5'd31);

        // Disabled write leaves the register untouched
        repeat (3) do_write(5'd3, 32'h1234_5678, 1'b0);
        check(5'd0, 5'd3);

        // R0 ignores writes
        do_write(5'd0, 32'hF0F0_F0F0, 1'b1);
        check(5'd0, 5'd0);

        // Basic writes
        do_write(5'd1, 32'h0F0F_0F0F, 1'b1);
        do_write(5'd2, 32'hFFFF_FFFF, 1'b1);
        check(5'd1, 5'd2);

        // Same-address read during write: old value before edge, new after
        do_write(5'd5, 32'hAAAA_AAAA, 1'b1);
        @(negedge Clk);
        bus.Adr1 = 5'd5;
        bus.Adr2 = 5'd5;
        bus.Awr  = 5'd5;
        bus.Din  = 32'h5555_5555;
        bus.WrEn = 1'b1;
        #1;
        push_check();
        @(posedge Clk);
        model[5] = 32'h5555_5555;
        #1;
        bus.WrEn = 1'b0;
        push_check();

        // Randomised traffic against the array model
        for (int n = 0; n < 150; n++) begin
            do_write(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            check(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset: outputs clear without a clock edge
        @(negedge Clk);
        bus.Adr1 = 5'd1;
        bus.Adr2 = 5'd31;
        #1;
        Rst = 1'b0;
        clear_model();
        #1;
        push_check();
        check(5'd0, 5'd5);

        // Write attempted while in reset must not land
        do_write(5'd31, 32'hDEAD_BEEF, 1'b1);
        @(negedge Clk);
        Rst = 1'b1;
        check(5'd31, 5'd1);

        // Full sweep
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA500_0000 | 32'(i), 1'b1);
        for (int i = 0; i < 32; i++) check(5'(i), 5'(31 - i));

        @(negedge Clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_32x32.md
# register_file_32x32

General-purpose register file for the 32-bit datapath: 32 registers of 32 bits each, with two independent asynchronous read ports and one synchronous write port. It feeds the ALU operand buses (Dout1/Dout2) and takes the write-back value on Din. Register 0 is hardwired to zero.

## Interface
- No parameters. Width 32 and depth 32 are fixed.
- Clk  input  1  system clock; all state updates occur on its rising edge.
- Rst  input  1  reset, asynchronous and active-low; clears every register to 0.
- Adr1  input  5  read address for port 1.
- Adr2  input  5  read address for port 2.
- Awr  input  5  write address.
- Din  input  32  write data.
- WrEn  input  1  write enable, active-high, sampled on the rising edge of Clk.
- Dout1  output  32  contents of register Adr1.
- Dout2  output  32  contents of register Adr2.

## Operation
- Storage is 32 × 32-bit registers, R0..R31.
- **Write:**
  - On the rising edge of Clk with Rst=1 and WrEn=1, R[Awr] <= Din.
  - With WrEn=0, no register changes.
- **R0:**
  - Writes to Awr=0 are ignored.
  - R0 always reads 32'h0000_0000.
- **Read:**
  - Dout1 = R[Adr1] and Dout2 = R[Adr2], purely combinational.
  - No clock is involved in reads.
  - Both ports may address the same register, and both show the same value.
- **Reset:**
  - While Rst=0, all registers are held at 0 regardless of Clk or WrEn, so Dout1 and Dout2 read 0 for any address.
  - Reset asserted mid-operation clears state immediately and overrides any write in progress.
- After power-up without reset, contents are undefined except R0. Reset must be applied before use.
- There is no internal write-to-read bypass.

## Timing
- **Write latency:** the new value is visible on Dout1/Dout2 after the rising edge that performs the write, within combinational delay. It is not visible before that edge.
- **Same-cycle read/write to the same address:** before the edge, the read port shows the old value. After the edge, it shows Din.
- **Read latency:** zero cycles. Outputs follow Adr1/Adr2 changes combinationally.
- **Reset:**
  - Assertion takes effect asynchronously; outputs go to 0 without waiting for a clock edge.
  - Deassertion is synchronised by the user. The first write can occur on the first rising edge after Rst goes high.
- Only one write per cycle is possible, so there are no simultaneous-write conflicts.

## Test plan
- **Reset:** assert Rst=0 after random writes -> Dout1=Dout2=0 for addresses 0, 1 and 31 immediately, with no clock edge needed. Release Rst -> registers remain 0 until written.
- **R0 protection:** Awr=0, Din=32'hF0F0_F0F0, WrEn=1 for one edge; then Adr1=0 -> Dout1=32'h0000_0000.
- **Basic writes:**
  - Awr=1, Din=32'h0F0F_0F0F, WrEn=1 for one edge.
  - Then Awr=2, Din=32'hFFFF_FFFF, WrEn=1 for one edge.
  - Then set Adr1=1, Adr2=2 -> Dout1=32'h0F0F_0F0F, Dout2=32'hFFFF_FFFF.
- **Disabled write and unwritten register:**
  - After reset, Awr=3, Din=32'h1234_5678, WrEn=0 across several edges.
  - Adr2=3 -> Dout2=0.
  - Adr1=0 -> Dout1=0.
- **Same-address read during write:**
  - R5=32'hAAAA_AAAA.
  - Set Adr1=Adr2=5, Awr=5, Din=32'h5555_5555, WrEn=1.
  - Before the edge -> both outputs read 32'hAAAA_AAAA.
  - After the edge -> both read 32'h5555_5555.
- **Full sweep:** write R[i]=32'hA5000000|i for i=1..31, then read every address on both ports -> each returns its pattern and address 0 returns 0. Also write R31 with WrEn=1 while Rst=0 -> R31 reads 0 after reset release.
